// File: rtl/pcie_us_msi_pkg.sv
// Shared types and constants for the function-0 MSI request arbiter.
package pcie_us_msi_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StWait    = 2'd2,
      StBackoff = 2'd3
   } msi_state_e;

   localparam int unsigned MSI_MAX  = 32;
   localparam logic [3:0]  FUNC_NUM = 4'd0;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pcie_us_msi_arb_if.sv
// MSI request/response signals of the PCIe hard block configuration interface.
interface pcie_us_msi_arb_if;
   logic [3:0]  cfg_interrupt_msi_enable;
   logic [11:0] cfg_interrupt_msi_mmenable;
   logic        cfg_interrupt_msi_mask_update;
   logic [31:0] cfg_interrupt_msi_data;
   logic [3:0]  cfg_interrupt_msi_select;
   logic [31:0] cfg_interrupt_msi_int;
   logic [31:0] cfg_interrupt_msi_pending_status;
   logic        cfg_interrupt_msi_pending_status_data_enable;
   logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
   logic        cfg_interrupt_msi_sent;
   logic        cfg_interrupt_msi_fail;
   logic [2:0]  cfg_interrupt_msi_attr;
   logic        cfg_interrupt_msi_tph_present;
   logic [1:0]  cfg_interrupt_msi_tph_type;
   logic [8:0]  cfg_interrupt_msi_tph_st_tag;
   logic [3:0]  cfg_interrupt_msi_function_number;

   // Arbiter side.
   modport master (
      input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
             cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
             cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
      output cfg_interrupt_msi_select, cfg_interrupt_msi_int,
             cfg_interrupt_msi_pending_status, cfg_interrupt_msi_pending_status_data_enable,
             cfg_interrupt_msi_pending_status_function_num, cfg_interrupt_msi_attr,
             cfg_interrupt_msi_tph_present, cfg_interrupt_msi_tph_type,
             cfg_interrupt_msi_tph_st_tag, cfg_interrupt_msi_function_number
   );

   // Hard block side.
   modport slave (
      output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
             cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
             cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
      input  cfg_interrupt_msi_select, cfg_interrupt_msi_int,
             cfg_interrupt_msi_pending_status, cfg_interrupt_msi_pending_status_data_enable,
             cfg_interrupt_msi_pending_status_function_num, cfg_interrupt_msi_attr,
             cfg_interrupt_msi_tph_present, cfg_interrupt_msi_tph_type,
             cfg_interrupt_msi_tph_st_tag, cfg_interrupt_msi_function_number
   );
endinterface

// File: rtl/msi_rr_arb.sv
// Combinational round-robin priority encoder: first set request at or after start, wrapping.
module msi_rr_arb #(
   parameter int unsigned N    = 32,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] start,
   output logic            grant_valid,
   output logic [IdxW-1:0] grant_index
);

   int              idx;
   logic [IdxW-1:0] sel;

   always_comb begin
      grant_valid = |req;
      grant_index = '0;
      idx         = 0;
      sel         = '0;
      // Descending scan so the closest request to start is assigned last.
      for (int j = int'(N) - 1; j >= 0; j--) begin
         idx = int'(start) + j;
         if (idx >= int'(N)) idx = idx - int'(N);
         sel = IdxW'(idx);
         if (req[sel]) grant_index = sel;
      end
   end

endmodule

// File: rtl/pcie_us_msi_arb.sv
// Captures MSI request edges, holds them pending and issues them one at a time, round-robin.
module pcie_us_msi_arb
   import pcie_us_msi_pkg::*;
#(
   parameter int unsigned MSI_COUNT   = 32,
   parameter int unsigned RETRY_DELAY = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MSI_COUNT-1:0] msi_irq,
   pcie_us_msi_arb_if.master    cfg,
   output logic [15:0]          msi_drop_count
);

   localparam int unsigned IdxW = idx_width(MSI_COUNT);
   localparam int unsigned CntW = idx_width(RETRY_DELAY);

   msi_state_e           state_q, state_d;
   logic [IdxW-1:0]      cur_q, cur_d, rr_q, rr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [MSI_COUNT-1:0] pending_q, pending_d, irq_last_q;
   logic [MSI_COUNT-1:0] rise, clr, allowed, merge;
   logic [31:0]          int_q, int_d;
   logic                 de_q;
   logic [15:0]          drop_q, drop_d;
   logic [16:0]          drop_sum;
   logic [6:0]           n_merge;
   logic                 grant_valid;
   logic [IdxW-1:0]      grant_index;
   logic [2:0]           mm;
   logic                 unused;

   assign unused = ^{cfg.cfg_interrupt_msi_enable[3:1], cfg.cfg_interrupt_msi_mmenable[11:3],
                     cfg.cfg_interrupt_msi_mask_update, cfg.cfg_interrupt_msi_data};

   assign mm   = cfg.cfg_interrupt_msi_mmenable[2:0];
   assign rise = msi_irq & ~irq_last_q;

   always_comb begin
      allowed = '0;
      for (int i = 0; i < int'(MSI_COUNT); i++) begin
         allowed[i] = cfg.cfg_interrupt_msi_enable[0] & ~cfg.cfg_interrupt_msi_data[i] &
                      ((mm >= 3'd5) || (i < (1 << mm)));
      end
   end

   msi_rr_arb #(
      .N    (MSI_COUNT),
      .IdxW (IdxW)
   ) u_rr_arb (
      .req         (pending_q & allowed),
      .start       (rr_q),
      .grant_valid (grant_valid),
      .grant_index (grant_index)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      clr     = '0;
      int_d   = '0;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               cur_d   = grant_index;
               state_d = StIssue;
            end
         end
         StIssue: begin
            int_d[cur_q] = 1'b1;
            state_d      = StWait;
         end
         StWait: begin
            // Sent takes priority over a simultaneous fail.
            if (cfg.cfg_interrupt_msi_sent) begin
               clr[cur_q] = 1'b1;
               rr_d       = (cur_q == IdxW'(MSI_COUNT - 1)) ? '0 : cur_q + 1'b1;
               state_d    = StIdle;
            end else if (cfg.cfg_interrupt_msi_fail) begin
               cnt_d   = CntW'(RETRY_DELAY - 1);
               state_d = StBackoff;
            end
         end
         StBackoff: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // A new edge wins over the sent-clear of the same vector and is not counted as a merge.
   always_comb begin
      pending_d = (pending_q & ~clr) | rise;
      merge     = rise & pending_q & ~clr;
      n_merge   = '0;
      for (int i = 0; i < int'(MSI_COUNT); i++) n_merge = n_merge + 7'(merge[i]);
      drop_sum  = {1'b0, drop_q} + 17'(n_merge);
      drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cur_q      <= '0;
         rr_q       <= '0;
         cnt_q      <= '0;
         pending_q  <= '0;
         irq_last_q <= '0;
         int_q      <= '0;
         de_q       <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         irq_last_q <= msi_irq;
         int_q      <= int_d;
         de_q       <= (pending_d != pending_q);
         drop_q     <= drop_d;
      end
   end

   always_comb begin
      cfg.cfg_interrupt_msi_pending_status                  = '0;
      cfg.cfg_interrupt_msi_pending_status[MSI_COUNT-1:0]   = pending_q;
   end

   assign cfg.cfg_interrupt_msi_int                        = int_q;
   assign cfg.cfg_interrupt_msi_pending_status_data_enable = de_q;
   assign cfg.cfg_interrupt_msi_select                     = FUNC_NUM;
   assign cfg.cfg_interrupt_msi_pending_status_function_num = FUNC_NUM;
   assign cfg.cfg_interrupt_msi_function_number            = FUNC_NUM;
   assign cfg.cfg_interrupt_msi_attr                       = '0;
   assign cfg.cfg_interrupt_msi_tph_present                = 1'b0;
   assign cfg.cfg_interrupt_msi_tph_type                   = '0;
   assign cfg.cfg_interrupt_msi_tph_st_tag                 = '0;
   assign msi_drop_count                                   = drop_q;

endmodule

// File: doc/pcie_us_msi_arb.md
Name: pcie_us_msi_arb

Overview:
Drives the MSI request side of the UltraScale+ PCIe hard block's configuration interface for function 0. It captures rising edges on per-vector interrupt request lines from the user core and holds them as pending. Vectors are arbitrated round-robin and issued one at a time on cfg_interrupt_msi_int, with retry on fail. It sits between the user core (interrupt sources) and the PCIe hard block's cfg_interrupt_msi_* ports.

Parameters:
MSI_COUNT, 32, number of vectors (1..32).
RETRY_DELAY, 64, cycles to wait after cfg_interrupt_msi_fail before re-arbitrating (>=1).

Ports:
clk  in  1  user clock (250 MHz PCIe user_clk).
rst  in  1  synchronous, active-high reset.
msi_irq  in  MSI_COUNT  per-vector request; a rising edge requests one MSI.
cfg_interrupt_msi_enable  in  4  per-function MSI enable; only bit 0 is used.
cfg_interrupt_msi_mmenable  in  12  multiple-message enable; only [2:0] (function 0) is used.
cfg_interrupt_msi_mask_update  in  1  mask change strobe; not used, accepted for completeness.
cfg_interrupt_msi_data  in  32  mask bits for the selected function.
cfg_interrupt_msi_select  out  4  fixed 0.
cfg_interrupt_msi_int  out  32  one-hot request pulse.
cfg_interrupt_msi_pending_status  out  32  pending vector bitmap.
cfg_interrupt_msi_pending_status_data_enable  out  1  pending-status write strobe.
cfg_interrupt_msi_pending_status_function_num  out  4  fixed 0.
cfg_interrupt_msi_sent  in  1  MSI issued.
cfg_interrupt_msi_fail  in  1  MSI rejected.
cfg_interrupt_msi_attr  out  3  fixed 0.
cfg_interrupt_msi_tph_present  out  1  fixed 0.
cfg_interrupt_msi_tph_type  out  2  fixed 0.
cfg_interrupt_msi_tph_st_tag  out  9  fixed 0.
cfg_interrupt_msi_function_number  out  4  fixed 0.
msi_drop_count  out  16  count of requests merged into an already-pending vector; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0; pending=0; irq_last=0; rr pointer=0; state=IDLE; retry counter=0; msi_drop_count=0.
- Edge detect: irq_last registered each cycle. rise = msi_irq & ~irq_last. At the edge sampling rise, the corresponding pending bit is set.
- Merge: if rise[i] occurs while pending[i]=1 and pending[i] is not cleared on that edge, increment msi_drop_count (saturating).
- Allowed mask:
  - allowed[i] = cfg_interrupt_msi_enable[0] & (i < 2^mmenable[2:0]) & ~cfg_interrupt_msi_data[i].
  - mmenable values >=5 allow all 32 vectors. Bits >= MSI_COUNT are never allowed.
- FSM states: IDLE, ISSUE, WAIT, BACKOFF.
  - IDLE: if (pending & allowed) is nonzero, the round-robin pick is made, starting the search at index rr. The picked index is latched as cur. Go to ISSUE.
  - ISSUE: cfg_interrupt_msi_int = 1<<cur for exactly one cycle. Go to WAIT.
  - WAIT: int = 0.
    - On sent: clear pending[cur], set rr = cur+1 (wraps to 0 at MSI_COUNT), go to IDLE.
    - On fail: keep pending, load retry counter = RETRY_DELAY-1, go to BACKOFF.
    - If sent and fail are both high, sent wins.
    - No timeout.
  - BACKOFF: decrement the counter each cycle; at 0 go to IDLE.
- Latency: rising edge sampled at edge k, so pending is set at k. IDLE picks at k+1. int is high during the cycle after edge k+2 (2-cycle request-to-int).
- Set-over-clear: if rise[cur] coincides with the sent-clear of pending[cur], pending[cur] stays 1 and msi_drop_count does not increment.
- Enable dropped or vector masked while in WAIT/BACKOFF: the current transaction completes normally. Masked vectors stay pending and are not issued until unmasked.
- Pending status: cfg_interrupt_msi_pending_status = pending (registered). data_enable pulses for 1 cycle on the cycle after pending changes.
- Reset mid-WAIT: returns to IDLE with pending cleared. A late sent/fail arriving after reset is ignored.

Decomposition:
- Package pcie_us_msi_pkg:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, BACKOFF=3);
  - MSI_MAX=32;
  - function 0 index constant.
- One sub-module: msi_rr_arb, a combinational round-robin priority encoder. Inputs: request vector and rr start index. Outputs: grant_valid and grant_index.

Test Plan:
- Pulse msi_irq[3] with enable=1, mmenable=5, mask=0 -> int=0x8 exactly 2 cycles after the rising edge; on sent, pending_status returns to 0 with a data_enable pulse.
- Rising edges on msi_irq[0], [5] and [31] in the same cycle, each answered with sent 3 cycles after int -> int sequence 0x1, 0x20, 0x80000000; rr then starts from 0 again.
- Answer int=0x4 with fail, RETRY_DELAY=64 -> int=0x4 reissued 66 cycles after the fail (64 backoff + IDLE + ISSUE); sent then clears pending.
- mmenable=2 (4 vectors), rise on msi_irq[6] -> no int, pending_status=0x40; then mmenable=3 -> int=0x40 issued.
- Mask bit 1 set, rise on [1] -> held pending, no int; clear the mask -> int=0x2. A second rise on [1] while pending -> msi_drop_count=1.
- Rise on msi_irq[2] in the same cycle as sent for cur=2 -> pending[2] remains 1, int=0x4 reissued, msi_drop_count unchanged; assert rst during WAIT -> all outputs 0 the next cycle.
